// File: rtl/seed_link_pkg.sv
// Shared types and constants for the seed exchange link.
package seed_link_pkg;

  localparam logic [7:0]  SEED_HDR       = 8'hA5;
  localparam int unsigned SEED_FRAME_LEN = 4;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_HDR,
    TX_X,
    TX_Y,
    TX_SUM
  } seed_tx_state;

  typedef enum logic [1:0] {
    RX_HDR,
    RX_X,
    RX_Y,
    RX_SUM
  } seed_rx_state;

  // Frame checksum: XOR of header and the two zero-extended seed bytes.
  function automatic logic [7:0] seed_sum(input logic [7:0] hdr,
                                          input logic [4:0] x,
                                          input logic [4:0] y);
    return hdr ^ {3'b000, x} ^ {3'b000, y};
  endfunction

endpackage

// File: rtl/seed_link_rx_parser.sv
// Receive side of the seed link: frame parser, inter-byte timeout and checksum.
module seed_rx_parser
  import seed_link_pkg::*;
#(
  parameter logic [7:0]  SEED_HDR   = 8'hA5,
  parameter int unsigned RX_TIMEOUT = 75000
) (
  input  logic       clk_75,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [4:0] seed_x_in,
  output logic [4:0] seed_y_in,
  output logic       seed_valid,
  output logic       frame_err
);

  localparam int unsigned CW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RX_TIMEOUT - 1);

  seed_rx_state    state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      xp_q, xp_d, yp_q, yp_d;
  logic [4:0]      sx_d, sy_d;
  logic            sv_d, fe_d;

  // State, partial-seed, timeout and output registers.
  always_ff @(posedge clk_75) begin
    if (rst) begin
      state_q    <= RX_HDR;
      cnt_q      <= '0;
      xp_q       <= '0;
      yp_q       <= '0;
      seed_x_in  <= '0;
      seed_y_in  <= '0;
      seed_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      xp_q       <= xp_d;
      yp_q       <= yp_d;
      seed_x_in  <= sx_d;
      seed_y_in  <= sy_d;
      seed_valid <= sv_d;
      frame_err  <= fe_d;
    end
  end

  // Next-state: a received byte always takes priority over an expiring timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xp_d    = xp_q;
    yp_d    = yp_q;
    sx_d    = seed_x_in;
    sy_d    = seed_y_in;
    sv_d    = 1'b0;
    fe_d    = 1'b0;
    if (rx_valid) begin
      cnt_d = '0;
      case (state_q)
        RX_HDR: begin
          if (rx_data == SEED_HDR) state_d = RX_X;
        end
        RX_X: begin
          if (rx_data[7:5] != 3'b000) begin
            fe_d    = 1'b1;
            state_d = RX_HDR;
          end else begin
            xp_d    = rx_data[4:0];
            state_d = RX_Y;
          end
        end
        RX_Y: begin
          if (rx_data[7:5] != 3'b000) begin
            fe_d    = 1'b1;
            state_d = RX_HDR;
          end else begin
            yp_d    = rx_data[4:0];
            state_d = RX_SUM;
          end
        end
        RX_SUM: begin
          state_d = RX_HDR;
          if (rx_data == seed_sum(SEED_HDR, xp_q, yp_q)) begin
            sx_d = xp_q;
            sy_d = yp_q;
            sv_d = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end
        default: state_d = RX_HDR;
      endcase
    end else if (state_q != RX_HDR) begin
      if (cnt_q == CNT_LAST) begin
        fe_d    = 1'b1;
        state_d = RX_HDR;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/seed_link.sv
// Seed exchange link: frames the local seed onto UART TX and parses the remote seed from RX.
module seed_link
  import seed_link_pkg::*;
#(
  parameter logic [7:0]  SEED_HDR   = 8'hA5,
  parameter int unsigned RX_TIMEOUT = 75000
) (
  input  logic       clk_75,
  input  logic       rst,
  input  logic       seed_rdy,
  input  logic [4:0] seed_x_local,
  input  logic [4:0] seed_y_local,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [4:0] seed_x_in,
  output logic [4:0] seed_y_in,
  output logic       seed_valid,
  output logic       frame_err,
  output logic       tx_busy
);

  seed_tx_state tx_state_q, tx_state_d;
  logic         seed_rdy_q;
  logic [4:0]   x_lat, y_lat;
  logic         trig;

  assign trig = seed_rdy && !seed_rdy_q;

  // Edge detector, TX state and seed latch; the seed is captured only from idle.
  always_ff @(posedge clk_75) begin
    if (rst) begin
      seed_rdy_q <= 1'b0;
      tx_state_q <= TX_IDLE;
      x_lat      <= '0;
      y_lat      <= '0;
    end else begin
      seed_rdy_q <= seed_rdy;
      tx_state_q <= tx_state_d;
      if (tx_state_q == TX_IDLE && trig) begin
        x_lat <= seed_x_local;
        y_lat <= seed_y_local;
      end
    end
  end

  // TX next-state and byte mux; each byte is held until the UART accepts it.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_valid   = 1'b0;
    tx_data    = '0;
    tx_busy    = (tx_state_q != TX_IDLE);
    case (tx_state_q)
      TX_IDLE: begin
        if (trig) tx_state_d = TX_HDR;
      end
      TX_HDR: begin
        tx_valid = 1'b1;
        tx_data  = SEED_HDR;
        if (tx_ready) tx_state_d = TX_X;
      end
      TX_X: begin
        tx_valid = 1'b1;
        tx_data  = {3'b000, x_lat};
        if (tx_ready) tx_state_d = TX_Y;
      end
      TX_Y: begin
        tx_valid = 1'b1;
        tx_data  = {3'b000, y_lat};
        if (tx_ready) tx_state_d = TX_SUM;
      end
      TX_SUM: begin
        tx_valid = 1'b1;
        tx_data  = seed_sum(SEED_HDR, x_lat, y_lat);
        if (tx_ready) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  seed_rx_parser #(
    .SEED_HDR   (SEED_HDR),
    .RX_TIMEOUT (RX_TIMEOUT)
  ) u_rx (
    .clk_75     (clk_75),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .seed_x_in  (seed_x_in),
    .seed_y_in  (seed_y_in),
    .seed_valid (seed_valid),
    .frame_err  (frame_err)
  );

endmodule

// File: tb/tb_seed_link.sv
// Bench for seed_link: cycle table for TX/RX framing plus directed stall, retrigger, timeout and reset sequences.
module tb_seed_link;
  import seed_link_pkg::*;

  localparam int unsigned TMO = 20;

  logic       clk_75 = 1'b0;
  logic       rst, seed_rdy, tx_ready, rx_valid;
  logic [4:0] seed_x_local, seed_y_local;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_valid, seed_valid, frame_err, tx_busy;
  logic [4:0] seed_x_in, seed_y_in;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk_75 = ~clk_75;

  seed_link #(
    .SEED_HDR   (8'hA5),
    .RX_TIMEOUT (TMO)
  ) dut (
    .clk_75       (clk_75),
    .rst          (rst),
    .seed_rdy     (seed_rdy),
    .seed_x_local (seed_x_local),
    .seed_y_local (seed_y_local),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .seed_x_in    (seed_x_in),
    .seed_y_in    (seed_y_in),
    .seed_valid   (seed_valid),
    .frame_err    (frame_err),
    .tx_busy      (tx_busy)
  );

  typedef struct {
    logic       rst, rdy;
    logic [4:0] x, y;
    logic       trdy;
    logic [7:0] rxd;
    logic       rxv;
    logic       e_tv;
    logic [7:0] e_td;
    logic       e_busy, e_sv, e_fe;
    logic [4:0] e_x, e_y;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t v(logic r, logic rdy, logic [4:0] x, logic [4:0] y, logic trdy,
                             logic [7:0] rxd, logic rxv, logic tv, logic [7:0] td,
                             logic busy, logic sv, logic fe, logic [4:0] ex, logic [4:0] ey);
    vec_t t;
    t.rst = r; t.rdy = rdy; t.x = x; t.y = y; t.trdy = trdy; t.rxd = rxd; t.rxv = rxv;
    t.e_tv = tv; t.e_td = td; t.e_busy = busy; t.e_sv = sv; t.e_fe = fe; t.e_x = ex; t.e_y = ey;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_75);
    @(negedge clk_75);
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  logic [7:0] got_b[8];
  int         got;
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       found;

  initial begin
    rst = 1'b1; seed_rdy = 1'b0; tx_ready = 1'b1; rx_valid = 1'b0;
    seed_x_local = '0; seed_y_local = '0; rx_data = '0;

    //            rst rdy x   y   trdy rxd    rxv  tv td     busy sv fe ex  ey
    tbl[0]  = v(1, 0, 0,  0,  1, 8'h00, 0,  0, 8'h00, 0, 0, 0, 0,  0);
    tbl[1]  = v(0, 1, 7,  13, 1, 8'h00, 0,  1, 8'hA5, 1, 0, 0, 0,  0);
    tbl[2]  = v(0, 1, 7,  13, 1, 8'h00, 0,  1, 8'h07, 1, 0, 0, 0,  0);
    tbl[3]  = v(0, 1, 7,  13, 1, 8'h00, 0,  1, 8'h0D, 1, 0, 0, 0,  0);
    tbl[4]  = v(0, 1, 7,  13, 1, 8'h00, 0,  1, 8'hAF, 1, 0, 0, 0,  0);
    tbl[5]  = v(0, 1, 7,  13, 1, 8'h00, 0,  0, 8'h00, 0, 0, 0, 0,  0);
    tbl[6]  = v(0, 0, 7,  13, 1, 8'h00, 0,  0, 8'h00, 0, 0, 0, 0,  0);
    tbl[7]  = v(0, 0, 7,  13, 1, 8'h00, 1,  0, 8'h00, 0, 0, 0, 0,  0);
    tbl[8]  = v(0, 0, 7,  13, 1, 8'hA5, 1,  0, 8'h00, 0, 0, 0, 0,  0);
    tbl[9]  = v(0, 0, 7,  13, 1, 8'h1E, 1,  0, 8'h00, 0, 0, 0, 0,  0);
    tbl[10] = v(0, 0, 7,  13, 1, 8'h16, 1,  0, 8'h00, 0, 0, 0, 0,  0);
    tbl[11] = v(0, 0, 7,  13, 1, 8'hAD, 1,  0, 8'h00, 0, 1, 0, 30, 22);
    tbl[12] = v(0, 0, 7,  13, 1, 8'h00, 0,  0, 8'h00, 0, 0, 0, 30, 22);
    tbl[13] = v(0, 0, 7,  13, 1, 8'hA5, 1,  0, 8'h00, 0, 0, 0, 30, 22);
    tbl[14] = v(0, 0, 7,  13, 1, 8'h07, 1,  0, 8'h00, 0, 0, 0, 30, 22);
    tbl[15] = v(0, 0, 7,  13, 1, 8'h0D, 1,  0, 8'h00, 0, 0, 0, 30, 22);
    tbl[16] = v(0, 0, 7,  13, 1, 8'hAE, 1,  0, 8'h00, 0, 0, 1, 30, 22);
    tbl[17] = v(0, 0, 7,  13, 1, 8'hA5, 1,  0, 8'h00, 0, 0, 0, 30, 22);
    tbl[18] = v(0, 0, 7,  13, 1, 8'h27, 1,  0, 8'h00, 0, 0, 1, 30, 22);
    tbl[19] = v(0, 0, 7,  13, 1, 8'h00, 0,  0, 8'h00, 0, 0, 0, 30, 22);
    tbl[20] = v(0, 1, 1,  2,  1, 8'hA5, 1,  1, 8'hA5, 1, 0, 0, 30, 22);
    tbl[21] = v(0, 1, 1,  2,  1, 8'h01, 1,  1, 8'h01, 1, 0, 0, 30, 22);
    tbl[22] = v(0, 1, 1,  2,  1, 8'h02, 1,  1, 8'h02, 1, 0, 0, 30, 22);
    tbl[23] = v(0, 1, 1,  2,  1, 8'hA6, 1,  1, 8'hA6, 1, 1, 0, 1,  2);
    tbl[24] = v(0, 1, 1,  2,  1, 8'h00, 0,  0, 8'h00, 0, 0, 0, 1,  2);

    @(negedge clk_75);
    for (int i = 0; i < 25; i++) begin
      rst = tbl[i].rst; seed_rdy = tbl[i].rdy; seed_x_local = tbl[i].x; seed_y_local = tbl[i].y;
      tx_ready = tbl[i].trdy; rx_data = tbl[i].rxd; rx_valid = tbl[i].rxv;
      step();
      chk($sformatf("r%0d_tx_valid", i), 32'(tx_valid), 32'(tbl[i].e_tv));
      chk($sformatf("r%0d_tx_data", i), 32'(tx_data), 32'(tbl[i].e_td));
      chk($sformatf("r%0d_tx_busy", i), 32'(tx_busy), 32'(tbl[i].e_busy));
      chk($sformatf("r%0d_seed_valid", i), 32'(seed_valid), 32'(tbl[i].e_sv));
      chk($sformatf("r%0d_frame_err", i), 32'(frame_err), 32'(tbl[i].e_fe));
      chk($sformatf("r%0d_seed_x_in", i), 32'(seed_x_in), 32'(tbl[i].e_x));
      chk($sformatf("r%0d_seed_y_in", i), 32'(seed_y_in), 32'(tbl[i].e_y));
    end
    rx_valid = 1'b0; rx_data = '0;

    // TX with tx_ready high only one cycle in three.
    seed_rdy = 1'b0; tx_ready = 1'b1; step();
    seed_rdy = 1'b1; seed_x_local = 5'd7; seed_y_local = 5'd13;
    got = 0; prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      step();
      if (prev_stall) begin
        chk("stall_valid", 32'(tx_valid), 32'd1);
        chk("stall_hold", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid) begin
        tx_ready = ((cyc % 3) == 2);
        if (tx_ready) begin
          if (got < 8) got_b[got] = tx_data;
          got++;
        end
        prev_stall = !tx_ready;
        prev_data  = tx_data;
      end else begin
        tx_ready   = 1'b1;
        prev_stall = 1'b0;
        if (got >= 4) break;
      end
    end
    chk("stall_count", 32'(got), 32'(SEED_FRAME_LEN));
    chk("stall_b0", 32'(got_b[0]), 32'h A5);
    chk("stall_b1", 32'(got_b[1]), 32'h07);
    chk("stall_b2", 32'(got_b[2]), 32'h0D);
    chk("stall_b3", 32'(got_b[3]), 32'hAF);
    chk("stall_busy_end", 32'(tx_busy), 32'd0);

    // Held seed_rdy plus a second edge during TX_X: one frame, first seed.
    seed_rdy = 1'b0; tx_ready = 1'b1; step();
    seed_rdy = 1'b1; seed_x_local = 5'd3; seed_y_local = 5'd9;
    got = 0;
    for (int cyc = 0; cyc < 102; cyc++) begin
      step();
      if (tx_valid) begin
        if (got < 8) got_b[got] = tx_data;
        got++;
      end
      if (cyc == 0) begin
        seed_rdy = 1'b0; seed_x_local = 5'd20; seed_y_local = 5'd20;
      end else begin
        seed_rdy = 1'b1;
      end
    end
    chk("hold_count", 32'(got), 32'(SEED_FRAME_LEN));
    chk("hold_b0", 32'(got_b[0]), 32'hA5);
    chk("hold_b1", 32'(got_b[1]), 32'h03);
    chk("hold_b2", 32'(got_b[2]), 32'h09);
    chk("hold_b3", 32'(got_b[3]), 32'hAF);
    seed_rdy = 1'b0; step();

    // RX timeout: frame_err exactly TMO idle cycles after the last byte.
    send_rx(8'hA5);
    send_rx(8'h07);
    for (int k = 1; k <= int'(TMO); k++) begin
      if (k < int'(TMO)) chk($sformatf("tmo_quiet_%0d", k), 32'(frame_err), 32'd0);
      step();
    end
    chk("tmo_err", 32'(frame_err), 32'd1);
    chk("tmo_sv", 32'(seed_valid), 32'd0);
    step();
    chk("tmo_err_pulse", 32'(frame_err), 32'd0);
    send_rx(8'hA5);
    send_rx(8'h05);
    send_rx(8'h06);
    send_rx(8'hA6);
    chk("after_tmo_sv", 32'(seed_valid), 32'd1);
    chk("after_tmo_fe", 32'(frame_err), 32'd0);
    chk("after_tmo_x", 32'(seed_x_in), 32'd5);
    chk("after_tmo_y", 32'(seed_y_in), 32'd6);
    step();
    chk("after_tmo_sv_pulse", 32'(seed_valid), 32'd0);

    // Byte arriving on the expiry cycle wins over the timeout.
    send_rx(8'hA5);
    send_rx(8'h07);
    for (int k = 1; k < int'(TMO); k++) step();
    chk("win_quiet", 32'(frame_err), 32'd0);
    send_rx(8'h0D);
    chk("win_no_err", 32'(frame_err), 32'd0);
    send_rx(8'hAF);
    chk("win_sv", 32'(seed_valid), 32'd1);
    chk("win_fe", 32'(frame_err), 32'd0);
    chk("win_x", 32'(seed_x_in), 32'd7);
    chk("win_y", 32'(seed_y_in), 32'd13);

    // Reset during TX_Y: everything returns to zero on the next cycle.
    seed_rdy = 1'b0; tx_ready = 1'b1; step();
    seed_rdy = 1'b1; seed_x_local = 5'd7; seed_y_local = 5'd13;
    found = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      step();
      if (tx_valid && tx_data == 8'h0D) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_reached_tx_y", 32'(found), 32'd1);
    rst = 1'b1; seed_rdy = 1'b0;
    step();
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_busy", 32'(tx_busy), 32'd0);
    chk("rst_seed_x", 32'(seed_x_in), 32'd0);
    chk("rst_seed_y", 32'(seed_y_in), 32'd0);
    chk("rst_seed_valid", 32'(seed_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_idle", 32'(tx_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
